// File: rtl/pipe_decoder.sv
// Registered one-hot decoder behind a 2-entry valid/ready buffer with 1-cycle latency.
// Optional macro PIPE_DECODER_ERR_CNT_EN adds an 8-bit saturating count of consumed error entries.
module pipe_decoder #(
    parameter int WIDTH = 5,
    parameter int OUTS  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUTS-1:0]  y,
    output logic             err,
    output logic             out_valid,
`ifdef PIPE_DECODER_ERR_CNT_EN
    output logic [7:0]       err_cnt,
`endif
    input  logic             out_ready
);

    typedef struct packed {
        logic [OUTS-1:0] y;
        logic            err;
    } entry_t;

    entry_t     dec;
    entry_t     head_q;
    entry_t     tail_q;
    logic [1:0] count_q;
    logic       push;
    logic       pop;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        dec = '0;
        if (en) begin
            if (int'(a) < OUTS) dec.y = OUTS'(1) << a;
            else                dec.err = 1'b1;
        end
    end

    // Reset gates readiness directly so nothing is accepted on a reset edge and the
    // buffer is ready the moment reset drops; out_ready never reaches this path.
    assign in_ready  = !rst && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Payload is masked when empty, so the drained buffer reads all-zero.
    assign y   = out_valid ? head_q.y   : '0;
    assign err = out_valid ? head_q.err : 1'b0;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
        end else if (push && !pop) begin
            count_q <= count_q + 2'd1;
        end else if (pop && !push) begin
            count_q <= count_q - 2'd1;
        end
    end

    // NOTE: buffer storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        case (count_q)
            2'd0: if (push) head_q <= dec;
            2'd1: begin
                if (push && pop) head_q <= dec;
                else if (push)   tail_q <= dec;
            end
            2'd2: if (pop) head_q <= tail_q;
            default: ;
        endcase
    end

`ifdef PIPE_DECODER_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (pop && head_q.err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
